// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: op codes, FSM states and shared helpers
// for the multi-cycle EX-stage ALU.
package seq_alu_pkg;

    localparam int MAX_W = 64;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_ADDU  = 4'b0100;
    localparam logic [3:0] OP_SUBU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_LUI   = 4'b1010;
    localparam logic [3:0] OP_SLTU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_RSVD  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    // Callers zero-extend into MAX_W and truncate back to their width.
    function automatic logic [MAX_W-1:0] mag(
        input logic [MAX_W-1:0] v,
        input logic             neg
    );
        return neg ? -v : v;
    endfunction

    function automatic logic is_muldiv(input logic [3:0] op);
        return op == OP_MULT || op == OP_MULTU ||
               op == OP_DIV  || op == OP_DIVU;
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative shift-add multiplier and restoring
// divider sharing one accumulator pair, with sign fix-up.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             launch,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             finish,
    output logic             div_zero,
    output logic             div_ovf,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [WIDTH-1:0] MIN =
        {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opd;
    logic             mode_mul;
    logic             neg_hi;
    logic             neg_lo;

    logic             is_mul;
    logic             is_div;
    logic             sgn;
    logic             sign_diff;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [2*WIDTH-1:0] prod;

    assign is_mul = op == OP_MULT || op == OP_MULTU;
    assign is_div = op == OP_DIV || op == OP_DIVU;
    assign sgn    = op == OP_MULT || op == OP_DIV;
    assign sign_diff = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);

    assign div_zero = is_div && b == '0;
    assign div_ovf  = op == OP_DIV && a == MIN && b == '1;

    assign a_mag = WIDTH'(mag(MAX_W'(a), sgn && a[WIDTH-1]));
    assign b_mag = WIDTH'(mag(MAX_W'(b), sgn && b[WIDTH-1]));

    // Multiply: add multiplicand into the upper half, shift right.
    assign add_sum = {1'b0, acc_hi} +
                     (acc_lo[0] ? {1'b0, opd} : '0);

    // Divide: remainder in acc_hi, dividend/quotient in acc_lo.
    assign shifted = {acc_hi, acc_lo[WIDTH-1]};
    assign trial   = shifted - {1'b0, opd};

    assign prod = {acc_hi, acc_lo};

    assign ready  = state == ST_IDLE;
    assign busy   = state == ST_MUL || state == ST_DIV ||
                    state == ST_FIX;
    assign finish = state == ST_FIX ||
                    (launch && (div_zero || div_ovf));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opd      <= '0;
            mode_mul <= 1'b0;
            neg_hi   <= 1'b0;
            neg_lo   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (launch) begin
                        cnt      <= '0;
                        acc_hi   <= '0;
                        mode_mul <= is_mul;
                        if (div_zero) begin
                            hi    <= a;
                            lo    <= '1;
                            state <= ST_DONE;
                        end else if (div_ovf) begin
                            hi    <= '0;
                            lo    <= MIN;
                            state <= ST_DONE;
                        end else if (is_mul) begin
                            acc_lo <= b_mag;
                            opd    <= a_mag;
                            neg_lo <= sign_diff;
                            neg_hi <= sign_diff;
                            state  <= ST_MUL;
                        end else begin
                            acc_lo <= a_mag;
                            opd    <= b_mag;
                            neg_lo <= sign_diff;
                            neg_hi <= sgn && a[WIDTH-1];
                            state  <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    acc_hi <= add_sum[WIDTH:1];
                    acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) state <= ST_FIX;
                end
                ST_DIV: begin
                    if (!trial[WIDTH]) begin
                        acc_hi <= trial[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= shifted[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= ST_FIX;
                end
                ST_FIX: begin
                    // Quotient truncates to zero; remainder follows dividend.
                    if (mode_mul) begin
                        {hi, lo} <= neg_lo ? -prod : prod;
                    end else begin
                        hi <= neg_hi ? -acc_hi : acc_hi;
                        lo <= neg_lo ? -acc_lo : acc_lo;
                    end
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: EX-stage ALU with single-cycle logic/arith ops and
// multi-cycle MULT/DIV into HI/LO; busy stalls the pipeline.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             z,
    output logic             ovf,
    output logic             div_by_zero
);

    logic             accept;
    logic             sc_go;
    logic             md_go;
    logic             finish;
    logic             div_zero;
    logic             div_ovf;
    logic             zsel;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res;
    logic             res_ovf;

    assign accept = start && ready;
    assign md_go  = accept && is_muldiv(op);
    assign sc_go  = accept && !is_muldiv(op);

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        unique case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_ADDU: res = sum;
            OP_SUBU: res = diff;
            OP_ADD: begin
                res     = sum;
                res_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res     = diff;
                res_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:
                res = {{(WIDTH-1){1'b0}},
                       $signed(a) < $signed(b)};
            OP_SLTU:
                res = {{(WIDTH-1){1'b0}}, a < b};
            OP_LUI:  res = b << (WIDTH / 2);
            default: res = '0;
        endcase
    end

    seq_alu_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clock    (clock),
        .reset_n  (reset_n),
        .launch   (md_go),
        .op       (op),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .busy     (busy),
        .finish   (finish),
        .div_zero (div_zero),
        .div_ovf  (div_ovf),
        .hi       (hi),
        .lo       (lo)
    );

    // Flags are cleared by every accepted op, then set by its outcome.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s           <= '0;
            zsel        <= 1'b0;
            ovf         <= 1'b0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= sc_go || finish;
            if (sc_go) begin
                s           <= res;
                zsel        <= 1'b0;
                ovf         <= res_ovf;
                div_by_zero <= 1'b0;
            end else if (md_go) begin
                zsel        <= 1'b1;
                ovf         <= div_ovf;
                div_by_zero <= div_zero;
            end
        end
    end

    assign z = zsel ? (hi == '0 && lo == '0) : (s == '0);

endmodule
